// File: rtl/step_seq_pkg.sv
// Shared definitions for the 2-bit step sequencer and its front-end conditioner.
package step_seq_pkg;

  typedef enum logic [1:0] {
    StIdle      = 2'b00,
    StPressWait = 2'b01,
    StHeld      = 2'b10,
    StRelWait   = 2'b11
  } step_state_e;

  localparam int unsigned DefDebounceCycles = 4;
  localparam int unsigned DefRepeatCycles   = 8;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; resets to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Plain two-stage shift; q is the second stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/step_pulse_conditioner.sv
// Debounces a raw push-button and emits a one-cycle step pulse per accepted press.
// Optional auto-repeat while held: define STEP_PULSE_AUTO_REPEAT_EN.
module step_pulse_conditioner
  import step_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
  parameter int unsigned REPEAT_CYCLES   = DefRepeatCycles
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  input  logic en,
  output logic x_out,
  output logic level,
  output logic busy
);

  localparam int unsigned CNT_W = $clog2(max_u(DEBOUNCE_CYCLES, REPEAT_CYCLES) + 1);
  localparam logic [CNT_W-1:0] CntTerm = CNT_W'(DEBOUNCE_CYCLES);

  logic             btn_s;
  step_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             x_q, x_d;
  logic             level_q, level_d;
  logic             busy_q, busy_d;
  logic             accept;
  logic             rep_hit;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (btn_s)
  );

  // State, debounce counter and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      x_q     <= 1'b0;
      level_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      level_q <= level_d;
      busy_q  <= busy_d;
    end
  end

  // Debounce FSM; counter only advances below its terminal value, so it never wraps
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (btn_s) begin
          state_d = StPressWait;
          cnt_d   = CNT_W'(1);
        end
      end
      StPressWait: begin
        if (!btn_s) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == CntTerm) begin
          state_d = StHeld;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StHeld: begin
        if (!btn_s) begin
          state_d = StRelWait;
          cnt_d   = CNT_W'(1);
        end
      end
      StRelWait: begin
        if (btn_s) begin
          state_d = StHeld;
          cnt_d   = '0;
        end else if (cnt_q == CntTerm) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef STEP_PULSE_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] RepTerm = CNT_W'(REPEAT_CYCLES - 1);

  logic [CNT_W-1:0] rcnt_q, rcnt_d;

  // Repeat only fires on a cycle that stays in HELD
  assign rep_hit = (state_q == StHeld) && btn_s && (rcnt_q == RepTerm);

  // Repeat counter: runs while held, frozen across release bounce, cleared in IDLE
  always_comb begin
    rcnt_d = rcnt_q;
    if (state_d == StIdle) begin
      rcnt_d = '0;
    end else if ((state_q == StPressWait) && (state_d == StHeld)) begin
      rcnt_d = '0;
    end else if ((state_q == StHeld) && btn_s) begin
      rcnt_d = rep_hit ? '0 : rcnt_q + CNT_W'(1);
    end
  end

  // Repeat counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rcnt_q <= '0;
    end else begin
      rcnt_q <= rcnt_d;
    end
  end
`else
  assign rep_hit = 1'b0;
`endif

  // Output decode; en only matters on the edge that would launch a pulse
  always_comb begin
    accept  = (state_q == StPressWait) && btn_s && (cnt_q == CntTerm);
    x_d     = en & (accept | rep_hit);
    level_d = (state_d == StHeld) || (state_d == StRelWait);
    busy_d  = (state_d == StPressWait) || (state_d == StRelWait);
  end

  assign x_out = x_q;
  assign level = level_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_step_pulse_conditioner.sv
// Self-checking bench for step_pulse_conditioner; pulse timing via an expected-cycle queue.
module tb_step_pulse_conditioner;

  logic clk = 1'b0;
  logic rst;
  logic btn_in;
  logic en;
  logic x_out, level, busy;
  logic x_out1, level1, busy1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_q[$];

  step_pulse_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_CYCLES   (8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .btn_in (btn_in),
    .en     (en),
    .x_out  (x_out),
    .level  (level),
    .busy   (busy)
  );

  step_pulse_conditioner #(
    .DEBOUNCE_CYCLES (1),
    .REPEAT_CYCLES   (8)
  ) dut1 (
    .clk    (clk),
    .rst    (rst),
    .btn_in (btn_in),
    .en     (en),
    .x_out  (x_out1),
    .level  (level1),
    .busy   (busy1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every x_out pulse must match the next expected cycle
  always @(negedge clk) begin
    int e;
    if (x_out === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pulse_unexpected: x_out=1 at cycle %0d, required no pulse", cyc);
      end else begin
        e = exp_q.pop_front();
        if (e != cyc) begin
          errors++;
          $display("FAIL pulse_cycle: pulse at cycle %0d, required cycle %0d", cyc, e);
        end
      end
    end
  end

  task automatic release_and_settle();
    @(negedge clk);
    btn_in = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (level !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL settle_idle: level=%b busy=%b, required 0 0", level, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    btn_in = 1'b0;
    en = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (x_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_x_out: got %b, required 0", x_out);
    end
    checks++;
    if (level !== 1'b0) begin
      errors++;
      $display("FAIL reset_level: got %b, required 0", level);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b, required 0", busy);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Leaves the button held with the FSM in HELD
  task automatic test_clean_press();
    @(negedge clk);
    btn_in = 1'b1;
    en = 1'b1;
    exp_q.push_back(cyc + 7);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checks++;
      if (busy !== ((k >= 2 && k <= 5) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL press_busy k=%0d: got %b, required %b", k, busy, (k >= 2 && k <= 5));
      end
      checks++;
      if (level !== ((k >= 6) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL press_level k=%0d: got %b, required %b", k, level, (k >= 6));
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL press_pulse_missing: %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_release_bounce();
    @(negedge clk);
    btn_in = 1'b0;
    repeat (2) @(negedge clk);
    btn_in = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (level !== 1'b1) begin
        errors++;
        $display("FAIL rel_bounce_level k=%0d: got %b, required 1", k, level);
      end
    end
    btn_in = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (level !== ((k < 6) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL release_level k=%0d: got %b, required %b", k, level, (k < 6));
      end
      checks++;
      if (busy !== ((k >= 2 && k <= 5) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL release_busy k=%0d: got %b, required %b", k, busy, (k >= 2 && k <= 5));
      end
    end
  endtask

  task automatic test_bounce_reject();
    logic [3:0] pat;
    pat = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      btn_in = pat[i];
      repeat (2) @(negedge clk);
      checks++;
      if (level !== 1'b0) begin
        errors++;
        $display("FAIL bounce_level i=%0d: got %b, required 0", i, level);
      end
    end
    btn_in = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || level !== 1'b0) begin
      errors++;
      $display("FAIL bounce_idle: busy=%b level=%b, required 0 0", busy, level);
    end
  endtask

  task automatic test_enable_gating();
    @(negedge clk);
    en = 1'b0;
    btn_in = 1'b1;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (k == 8) en = 1'b1;
      checks++;
      if (level !== ((k >= 6) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL gate_level k=%0d: got %b, required %b", k, level, (k >= 6));
      end
    end
    release_and_settle();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    btn_in = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy_before: got %b, required 1", busy);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (x_out !== 1'b0 || level !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs: x_out=%b level=%b busy=%b, required 0 0 0",
               x_out, level, busy);
    end
    @(negedge clk);
    rst = 1'b1;
    exp_q.push_back(cyc + 7);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checks++;
      if (level !== ((k >= 6) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL mid_relaunch_level k=%0d: got %b, required %b", k, level, (k >= 6));
      end
    end
    release_and_settle();
  endtask

  task automatic test_debounce_one();
    @(negedge clk);
    btn_in = 1'b1;
    exp_q.push_back(cyc + 7);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (busy1 !== ((k == 2) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL d1_busy k=%0d: got %b, required %b", k, busy1, (k == 2));
      end
      checks++;
      if (x_out1 !== ((k == 3) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL d1_x_out k=%0d: got %b, required %b", k, x_out1, (k == 3));
      end
      checks++;
      if (level1 !== ((k >= 3) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL d1_level k=%0d: got %b, required %b", k, level1, (k >= 3));
      end
    end
    release_and_settle();
  endtask

`ifdef STEP_PULSE_AUTO_REPEAT_EN
  task automatic test_auto_repeat();
    int seq;
    seq = 0;
    @(negedge clk);
    btn_in = 1'b1;
    for (int p = 0; p < 4; p++) exp_q.push_back(cyc + 7 + 8 * p);
    for (int k = 0; k < 34; k++) begin
      @(negedge clk);
      if (x_out === 1'b1) seq = (seq + 1) % 4;
    end
    release_and_settle();
    checks++;
    if (seq != 0) begin
      errors++;
      $display("FAIL repeat_seq_wrap: sequencer code %0d, required 0", seq);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_clean_press();
    test_release_bounce();
    test_bounce_reject();
    test_enable_gating();
    test_reset_mid();
    test_debounce_one();
`ifdef STEP_PULSE_AUTO_REPEAT_EN
    test_auto_repeat();
`endif
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pulse_missing_end: %0d pending, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
